// File: rtl/watch_pkg.sv
// Shared types, field limits and wrap-around step helpers for the watch time-setting path.
package watch_pkg;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    SET_H  = 2'd1,
    SET_M  = 2'd2,
    SET_S  = 2'd3
  } state_t;

  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [4:0] HOUR_MAX = 5'd23;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_H    = 2'd1;
  localparam logic [1:0] FIELD_M    = 2'd2;
  localparam logic [1:0] FIELD_S    = 2'd3;

  // Step a 6-bit field by one with wrap; the sum is checked against max before wrapping
  function automatic logic [5:0] step6(input logic [5:0] val, input logic [5:0] max, input logic up);
    logic [5:0] sum;
    logic [5:0] res;
    sum = val + 6'd1;
    if (up) begin
      res = (sum > max) ? 6'd0 : sum;
    end else begin
      res = (val == 6'd0) ? max : val - 6'd1;
    end
    return res;
  endfunction

  function automatic logic [4:0] step5(input logic [4:0] val, input logic [4:0] max, input logic up);
    logic [4:0] sum;
    logic [4:0] res;
    sum = val + 5'd1;
    if (up) begin
      res = (sum > max) ? 5'd0 : sum;
    end else begin
      res = (val == 5'd0) ? max : val - 5'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for a debounced button; prev resets high so a button held through reset gives no edge.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  logic prev;

  // Previous-level register
  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= 1'b1;
    end else begin
      prev <= btn;
    end
  end

  assign rise = btn & ~prev;

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting controller: mode/up/down buttons edit hours -> minutes -> seconds and load the counter.
// Optional edit-mode timeout is compiled in with the SET_TIMEOUT_EN macro.
module time_set_ctrl
`ifdef SET_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_S = 30)
`endif
(
  input  logic       clk_100MHz_i,
  input  logic       reset_i,
  input  logic       seconds_pulse_i,
  input  logic       btn_mode_i,
  input  logic       btn_up_i,
  input  logic       btn_down_i,
  input  logic [5:0] cur_seconds_i,
  input  logic [5:0] cur_minutes_i,
  input  logic [4:0] cur_hours_i,
  output logic [5:0] load_seconds_o,
  output logic [5:0] load_minutes_o,
  output logic [4:0] load_hours_o,
  output logic       load_time_o,
  output logic       count_enable_o,
  output logic [1:0] edit_field_o,
  output logic       blink_o
);

  import watch_pkg::*;

  logic       mode_rise;
  logic       up_rise;
  logic       down_rise;
  logic       any_rise;
  logic       timeout_hit;
  state_t     state;
  state_t     next_state;
  logic       load_time_nxt;
  logic       count_enable_nxt;
  logic [1:0] edit_field_nxt;
  logic       blink_nxt;

  btn_edge u_mode (.clk(clk_100MHz_i), .reset(reset_i), .btn(btn_mode_i), .rise(mode_rise));
  btn_edge u_up   (.clk(clk_100MHz_i), .reset(reset_i), .btn(btn_up_i),   .rise(up_rise));
  btn_edge u_down (.clk(clk_100MHz_i), .reset(reset_i), .btn(btn_down_i), .rise(down_rise));

  assign any_rise = mode_rise | up_rise | down_rise;

`ifdef SET_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_S + 1);
  logic [TW-1:0] tmo_cnt;

  // Idle-seconds counter; any button edge or state change restarts it
  always_ff @(posedge clk_100MHz_i) begin
    if (reset_i) begin
      tmo_cnt <= '0;
    end else if (any_rise || (next_state != state)) begin
      tmo_cnt <= '0;
    end else if ((state != NORMAL) && seconds_pulse_i) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  // A button edge in the expiry cycle counts as activity and keeps the edit alive
  assign timeout_hit = (state != NORMAL) && (tmo_cnt == TW'(TIMEOUT_S)) && !any_rise;
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_100MHz_i) begin
    if (reset_i) begin
      state <= NORMAL;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      NORMAL: begin
        if (mode_rise) next_state = SET_H;
        else           next_state = NORMAL;
      end
      SET_H: begin
        if (timeout_hit)    next_state = NORMAL;
        else if (mode_rise) next_state = SET_M;
        else                next_state = SET_H;
      end
      SET_M: begin
        if (timeout_hit)    next_state = NORMAL;
        else if (mode_rise) next_state = SET_S;
        else                next_state = SET_M;
      end
      SET_S: begin
        if (timeout_hit || mode_rise) next_state = NORMAL;
        else                          next_state = SET_S;
      end
      default: next_state = NORMAL;
    endcase
  end

  // Output decode, computed one cycle ahead so every output leaves a register
  always_comb begin
    load_time_nxt    = 1'b0;
    count_enable_nxt = 1'b1;
    edit_field_nxt   = FIELD_NONE;
    blink_nxt        = 1'b0;

    // Only a committed exit from seconds edit loads; timeout never carries a mode edge
    if ((state == SET_S) && mode_rise) begin
      load_time_nxt = 1'b1;
    end else begin
      load_time_nxt = 1'b0;
    end

    case (next_state)
      NORMAL: begin
        count_enable_nxt = 1'b1;
        edit_field_nxt   = FIELD_NONE;
      end
      SET_H: begin
        count_enable_nxt = 1'b0;
        edit_field_nxt   = FIELD_H;
      end
      SET_M: begin
        count_enable_nxt = 1'b0;
        edit_field_nxt   = FIELD_M;
      end
      SET_S: begin
        count_enable_nxt = 1'b0;
        edit_field_nxt   = FIELD_S;
      end
      default: begin
        count_enable_nxt = 1'b1;
        edit_field_nxt   = FIELD_NONE;
      end
    endcase

    if ((next_state == NORMAL) || (state == NORMAL)) begin
      blink_nxt = 1'b0;
    end else if (seconds_pulse_i) begin
      blink_nxt = ~blink_o;
    end else begin
      blink_nxt = blink_o;
    end
  end

  // Control output registers
  always_ff @(posedge clk_100MHz_i) begin
    if (reset_i) begin
      load_time_o    <= 1'b0;
      count_enable_o <= 1'b1;
      edit_field_o   <= FIELD_NONE;
      blink_o        <= 1'b0;
    end else begin
      load_time_o    <= load_time_nxt;
      count_enable_o <= count_enable_nxt;
      edit_field_o   <= edit_field_nxt;
      blink_o        <= blink_nxt;
    end
  end

  // Edit registers double as the load bus; mode wins over up/down, up+down together cancel
  always_ff @(posedge clk_100MHz_i) begin
    if (reset_i) begin
      load_hours_o   <= 5'd0;
      load_minutes_o <= 6'd0;
      load_seconds_o <= 6'd0;
    end else if (state == NORMAL) begin
      if (mode_rise) begin
        load_hours_o   <= cur_hours_i;
        load_minutes_o <= cur_minutes_i;
        load_seconds_o <= cur_seconds_i;
      end
    end else if (!mode_rise && (up_rise != down_rise)) begin
      case (state)
        SET_H:   load_hours_o   <= step5(load_hours_o, HOUR_MAX, up_rise);
        SET_M:   load_minutes_o <= step6(load_minutes_o, MIN_MAX, up_rise);
        SET_S:   load_seconds_o <= step6(load_seconds_o, SEC_MAX, up_rise);
        default: load_hours_o   <= load_hours_o;
      endcase
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Table-driven bench for time_set_ctrl: one vector per clock, expected outputs go through a scoreboard queue.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       seconds_pulse_i;
  logic       btn_mode_i;
  logic       btn_up_i;
  logic       btn_down_i;
  logic [5:0] cur_seconds_i;
  logic [5:0] cur_minutes_i;
  logic [4:0] cur_hours_i;
  logic [5:0] load_seconds_o;
  logic [5:0] load_minutes_o;
  logic [4:0] load_hours_o;
  logic       load_time_o;
  logic       count_enable_o;
  logic [1:0] edit_field_o;
  logic       blink_o;

  always #5 clk = ~clk;

`ifdef SET_TIMEOUT_EN
  time_set_ctrl #(.TIMEOUT_S(3)) dut (
`else
  time_set_ctrl dut (
`endif
    .clk_100MHz_i   (clk),
    .reset_i        (reset_i),
    .seconds_pulse_i(seconds_pulse_i),
    .btn_mode_i     (btn_mode_i),
    .btn_up_i       (btn_up_i),
    .btn_down_i     (btn_down_i),
    .cur_seconds_i  (cur_seconds_i),
    .cur_minutes_i  (cur_minutes_i),
    .cur_hours_i    (cur_hours_i),
    .load_seconds_o (load_seconds_o),
    .load_minutes_o (load_minutes_o),
    .load_hours_o   (load_hours_o),
    .load_time_o    (load_time_o),
    .count_enable_o (count_enable_o),
    .edit_field_o   (edit_field_o),
    .blink_o        (blink_o)
  );

  typedef struct packed {
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic       lt;
    logic       ce;
    logic [1:0] fld;
    logic       blk;
  } out_t;

  typedef struct {
    string      name;
    logic       rst;
    logic       mode;
    logic       up;
    logic       down;
    logic       pulse;
    logic [4:0] ch;
    logic [5:0] cm;
    logic [5:0] cs;
    out_t       exp;
  } vec_t;

  vec_t  vecs[$];
  out_t  sb_exp[$];
  string sb_name[$];
  int    checks = 0;
  int    errors = 0;
  int    th, tm, ts;

  task automatic set_cur(input int h, input int m, input int s);
    th = h; tm = m; ts = s;
  endtask

  function automatic out_t mk_out(input int eh, input int em, input int es, input int lt, input int ce,
                                  input int f, input int b);
    out_t o;
    o.h   = eh[4:0];
    o.m   = em[5:0];
    o.s   = es[5:0];
    o.lt  = (lt != 0);
    o.ce  = (ce != 0);
    o.fld = f[1:0];
    o.blk = (b != 0);
    return o;
  endfunction

  task automatic check_out(input string nm, input out_t exp);
    out_t got;
    got = {load_hours_o, load_minutes_o, load_seconds_o, load_time_o,
           count_enable_o, edit_field_o, blink_o};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got h=%0d m=%0d s=%0d lt=%b ce=%b fld=%0d blk=%b, expected h=%0d m=%0d s=%0d lt=%b ce=%b fld=%0d blk=%b",
               nm, got.h, got.m, got.s, got.lt, got.ce, got.fld, got.blk,
               exp.h, exp.m, exp.s, exp.lt, exp.ce, exp.fld, exp.blk);
    end
  endtask

  task automatic add(input string nm, input int r, input int md, input int u, input int d, input int p,
                     input int eh, input int em, input int es, input int lt, input int ce,
                     input int f, input int b);
    vec_t v;
    v.name  = nm;
    v.rst   = (r != 0);
    v.mode  = (md != 0);
    v.up    = (u != 0);
    v.down  = (d != 0);
    v.pulse = (p != 0);
    v.ch    = th[4:0];
    v.cm    = tm[5:0];
    v.cs    = ts[5:0];
    v.exp   = mk_out(eh, em, es, lt, ce, f, b);
    vecs.push_back(v);
  endtask

  initial begin
    out_t  exp;
    string nm;

    reset_i = 1'b1; seconds_pulse_i = 1'b0;
    btn_mode_i = 1'b0; btn_up_i = 1'b0; btn_down_i = 1'b0;
    cur_hours_i = 5'd0; cur_minutes_i = 6'd0; cur_seconds_i = 6'd0;

    //  name            rst md up dn p   h  m  s  lt ce f b
    set_cur(13, 45, 7);
    add("reset0",        1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0);
    add("reset1",        1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0);
    add("idle",          0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0);
    add("pulse_normal",  0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 0, 0);
    add("enter_snap",    0, 1, 0, 0, 0, 13,45, 7, 0, 0, 1, 0);
    add("mode_held",     0, 1, 0, 0, 0, 13,45, 7, 0, 0, 1, 0);
    add("mode_rel",      0, 0, 0, 0, 0, 13,45, 7, 0, 0, 1, 0);
    add("h_up1",         0, 0, 1, 0, 0, 14,45, 7, 0, 0, 1, 0);
    add("up_held",       0, 0, 1, 0, 0, 14,45, 7, 0, 0, 1, 0);
    add("up_rel",        0, 0, 0, 0, 0, 14,45, 7, 0, 0, 1, 0);
    add("h_up2",         0, 0, 1, 0, 0, 15,45, 7, 0, 0, 1, 0);
    add("up_rel2",       0, 0, 0, 0, 0, 15,45, 7, 0, 0, 1, 0);
    add("blink_on",      0, 0, 0, 0, 1, 15,45, 7, 0, 0, 1, 1);
    add("blink_hold",    0, 0, 0, 0, 0, 15,45, 7, 0, 0, 1, 1);
    add("to_min",        0, 1, 0, 0, 0, 15,45, 7, 0, 0, 2, 1);
    add("to_min_rel",    0, 0, 0, 0, 0, 15,45, 7, 0, 0, 2, 1);
    add("m_down",        0, 0, 0, 1, 0, 15,44, 7, 0, 0, 2, 1);
    add("down_rel",      0, 0, 0, 0, 0, 15,44, 7, 0, 0, 2, 1);
    add("to_sec",        0, 1, 0, 0, 0, 15,44, 7, 0, 0, 3, 1);
    add("to_sec_rel",    0, 0, 0, 0, 0, 15,44, 7, 0, 0, 3, 1);
    add("exit_load",     0, 1, 0, 0, 0, 15,44, 7, 1, 1, 0, 0);
    add("load_one_cyc",  0, 0, 0, 0, 0, 15,44, 7, 0, 1, 0, 0);
    add("up_in_normal",  0, 0, 1, 0, 0, 15,44, 7, 0, 1, 0, 0);
    add("up_normal_rel", 0, 0, 0, 0, 0, 15,44, 7, 0, 1, 0, 0);

    set_cur(23, 0, 59);
    add("enter2",        0, 1, 0, 0, 0, 23, 0,59, 0, 0, 1, 0);
    add("rel2a",         0, 0, 0, 0, 0, 23, 0,59, 0, 0, 1, 0);
    add("h_wrap_up",     0, 0, 1, 0, 0,  0, 0,59, 0, 0, 1, 0);
    add("rel2b",         0, 0, 0, 0, 0,  0, 0,59, 0, 0, 1, 0);
    add("to_min2",       0, 1, 0, 0, 0,  0, 0,59, 0, 0, 2, 0);
    add("rel2c",         0, 0, 0, 0, 0,  0, 0,59, 0, 0, 2, 0);
    add("m_wrap_down",   0, 0, 0, 1, 0,  0,59,59, 0, 0, 2, 0);
    add("rel2d",         0, 0, 0, 0, 0,  0,59,59, 0, 0, 2, 0);
    add("up_down_same",  0, 0, 1, 1, 0,  0,59,59, 0, 0, 2, 0);
    add("rel2e",         0, 0, 0, 0, 0,  0,59,59, 0, 0, 2, 0);
    add("to_sec2",       0, 1, 0, 0, 0,  0,59,59, 0, 0, 3, 0);
    add("rel2f",         0, 0, 0, 0, 0,  0,59,59, 0, 0, 3, 0);
    add("s_wrap_up",     0, 0, 1, 0, 0,  0,59, 0, 0, 0, 3, 0);
    add("rel2g",         0, 0, 0, 0, 0,  0,59, 0, 0, 0, 3, 0);
    add("exit2_load",    0, 1, 0, 0, 0,  0,59, 0, 1, 1, 0, 0);
    add("rel2h",         0, 0, 0, 0, 0,  0,59, 0, 0, 1, 0, 0);

    set_cur(0, 30, 0);
    add("enter3",        0, 1, 0, 0, 0,  0,30, 0, 0, 0, 1, 0);
    add("rel3a",         0, 0, 0, 0, 0,  0,30, 0, 0, 0, 1, 0);
    add("h_wrap_down",   0, 0, 0, 1, 0, 23,30, 0, 0, 0, 1, 0);
    add("rel3b",         0, 0, 0, 0, 0, 23,30, 0, 0, 0, 1, 0);
    add("mode_up_same",  0, 1, 1, 0, 0, 23,30, 0, 0, 0, 2, 0);
    add("rel3c",         0, 0, 0, 0, 0, 23,30, 0, 0, 0, 2, 0);
    add("reset_mid",     1, 1, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0);
    add("reset_held",    1, 1, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0);
    add("held_no_edge",  0, 1, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0);
    add("held_rel",      0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0);

`ifdef SET_TIMEOUT_EN
    set_cur(8, 9, 10);
    add("t_enter",       0, 1, 0, 0, 0,  8, 9,10, 0, 0, 1, 0);
    add("t_rel",         0, 0, 0, 0, 0,  8, 9,10, 0, 0, 1, 0);
    add("t_p1",          0, 0, 0, 0, 1,  8, 9,10, 0, 0, 1, 1);
    add("t_i1",          0, 0, 0, 0, 0,  8, 9,10, 0, 0, 1, 1);
    add("t_p2",          0, 0, 0, 0, 1,  8, 9,10, 0, 0, 1, 0);
    add("t_i2",          0, 0, 0, 0, 0,  8, 9,10, 0, 0, 1, 0);
    add("t_p3",          0, 0, 0, 0, 1,  8, 9,10, 0, 0, 1, 1);
    add("t_expire",      0, 0, 0, 0, 0,  8, 9,10, 0, 1, 0, 0);
    add("t_after",       0, 0, 0, 0, 0,  8, 9,10, 0, 1, 0, 0);
    add("t2_enter",      0, 1, 0, 0, 0,  8, 9,10, 0, 0, 1, 0);
    add("t2_rel",        0, 0, 0, 0, 0,  8, 9,10, 0, 0, 1, 0);
    add("t2_p1",         0, 0, 0, 0, 1,  8, 9,10, 0, 0, 1, 1);
    add("t2_p2",         0, 0, 0, 0, 1,  8, 9,10, 0, 0, 1, 0);
    add("t2_up",         0, 0, 1, 0, 0,  9, 9,10, 0, 0, 1, 0);
    add("t2_up_rel",     0, 0, 0, 0, 0,  9, 9,10, 0, 0, 1, 0);
    add("t2_p3_alive",   0, 0, 0, 0, 1,  9, 9,10, 0, 0, 1, 1);
    add("t2_idle",       0, 0, 0, 0, 0,  9, 9,10, 0, 0, 1, 1);
    add("t2_p4",         0, 0, 0, 0, 1,  9, 9,10, 0, 0, 1, 0);
    add("t2_p5",         0, 0, 0, 0, 1,  9, 9,10, 0, 0, 1, 1);
    add("t2_expire",     0, 0, 0, 0, 0,  9, 9,10, 0, 1, 0, 0);
`endif

    @(posedge clk);
    #1;
    check_out("reset_state", mk_out(0, 0, 0, 0, 1, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset_i         = vecs[i].rst;
      btn_mode_i      = vecs[i].mode;
      btn_up_i        = vecs[i].up;
      btn_down_i      = vecs[i].down;
      seconds_pulse_i = vecs[i].pulse;
      cur_hours_i     = vecs[i].ch;
      cur_minutes_i   = vecs[i].cm;
      cur_seconds_i   = vecs[i].cs;
      sb_exp.push_back(vecs[i].exp);
      sb_name.push_back(vecs[i].name);

      @(posedge clk);
      #1;
      exp = sb_exp.pop_front();
      nm  = sb_name.pop_front();
      check_out(nm, exp);
    end

`ifdef SET_TIMEOUT_EN
    @(negedge clk);
    reset_i         = 1'b0;
    btn_mode_i      = 1'b0;
    btn_up_i        = 1'b0;
    btn_down_i      = 1'b0;
    seconds_pulse_i = 1'b0;
    @(posedge clk);
    #1;
    check_out("expired_wait", mk_out(9, 9, 10, 0, 1, 0, 0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
